// File: rtl/bit_to_byte_packer.sv
// bit_to_byte_packer
//   Packs the serial descrambled bit stream into MSB-first bytes and frames
//   each LENGTH_PACK-bit packet with start/end markers. A packet cut short
//   by a new start-of-packet is discarded and flagged on oerr.
//
//   Optional macro DEPACK_STAT_EN adds completed/aborted packet counters.
//
// Ports:
//   iclk      system clock, rising edge
//   ireset    asynchronous active-low reset
//   isop      first bit of a packet (qualified by ival)
//   ival      idat valid this cycle
//   idat      descrambled data bit
//   oval      odat holds a complete byte (one-cycle pulse per byte)
//   osop      first byte of a packet (only with oval)
//   oeop      last byte of a packet (only with oval)
//   odat      assembled byte, first received bit in odat[7]
//   oerr      one-cycle pulse: current packet aborted short
//   opkt_cnt  completed-packet counter (DEPACK_STAT_EN only)
//   oerr_cnt  aborted-packet counter (DEPACK_STAT_EN only)
module bit_to_byte_packer #(
  parameter int unsigned LENGTH_PACK = 1904,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       isop,
  input  logic       ival,
  input  logic       idat,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic [7:0] odat,
  output logic       oerr
`ifdef DEPACK_STAT_EN
  ,
  output logic [15:0] opkt_cnt,
  output logic [15:0] oerr_cnt
`endif
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH_PACK - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       sh, sh_nxt;
  logic             byte_done, byte_sop, byte_eop, abort;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    byte_done = 1'b0;
    byte_sop  = 1'b0;
    byte_eop  = 1'b0;
    abort     = 1'b0;
    if (ival) begin
      if (isop) begin
        // A start bit always opens a new packet; in RUN it also kills the
        // partial one, including any partial byte held in sh.
        abort     = (state == ST_RUN);
        state_nxt = ST_RUN;
        cnt_nxt   = CNT_W'(1);
        sh_nxt    = {6'b0, idat};
      end else if (state == ST_RUN) begin
        sh_nxt  = {sh[5:0], idat};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt[2:0] == 3'd7) begin
          byte_done = 1'b1;
          byte_sop  = (cnt[CNT_W-1:3] == '0);
          byte_eop  = (cnt == LAST_BIT);
        end
        if (cnt == LAST_BIT) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      oerr <= 1'b0;
      odat <= '0;
    end else begin
      oval <= byte_done;
      osop <= byte_sop;
      oeop <= byte_eop;
      oerr <= abort;
      if (byte_done) begin
        odat <= {sh, idat};
      end
    end
  end

`ifdef DEPACK_STAT_EN
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      opkt_cnt <= '0;
      oerr_cnt <= '0;
    end else begin
      if (oval && oeop) begin
        opkt_cnt <= opkt_cnt + 16'd1;
      end
      if (oerr) begin
        oerr_cnt <= oerr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bit_to_byte_packer.sv
// tb_bit_to_byte_packer
//   Table-driven stimulus rows plus hand-written abort/reset sequences.
//   Expected bytes and error pulses are queued as bits are driven and
//   checked against the DUT output stream by a monitor.
module tb_bit_to_byte_packer;

  localparam int unsigned LP = 1904;

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       isop = 1'b0;
  logic       ival = 1'b0;
  logic       idat = 1'b0;
  logic       oval, osop, oeop, oerr;
  logic [7:0] odat;
`ifdef DEPACK_STAT_EN
  logic [15:0] opkt_cnt, oerr_cnt;
`endif

  bit_to_byte_packer #(
    .LENGTH_PACK(LP),
    .CNT_W(11)
  ) dut (
    .iclk(iclk),
    .ireset(ireset),
    .isop(isop),
    .ival(ival),
    .idat(idat),
    .oval(oval),
    .osop(osop),
    .oeop(oeop),
    .odat(odat),
    .oerr(oerr)
`ifdef DEPACK_STAT_EN
    ,
    .opkt_cnt(opkt_cnt),
    .oerr_cnt(oerr_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  int unsigned cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  dat;
    bit          sop;
    bit          eop;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    int unsigned nbits;
    bit          sop;
    bit          gap;
    int unsigned seed;
    int unsigned exp_bytes;
    int unsigned exp_errs;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned err_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned rx_bytes = 0;
  int unsigned rx_errs = 0;

  // Reference packet model state
  bit          in_pkt = 1'b0;
  int unsigned idx = 0;
  int unsigned mod_pkts = 0;
  int unsigned mod_errs = 0;

  // Output monitor
  always @(negedge iclk) begin
    if (oval) begin
      exp_t e;
      checks++;
      rx_bytes++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got dat=%h sop=%0d eop=%0d at cyc %0d", odat, osop, oeop, cyc);
      end else begin
        e = exp_q.pop_front();
        if (odat !== e.dat || osop !== e.sop || oeop !== e.eop || cyc != e.cyc) begin
          errors++;
          $display("FAIL byte got dat=%h sop=%0d eop=%0d cyc=%0d want dat=%h sop=%0d eop=%0d cyc=%0d",
                   odat, osop, oeop, cyc, e.dat, e.sop, e.eop, e.cyc);
        end
      end
    end else if (osop !== 1'b0 || oeop !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL marker_without_oval got sop=%0d eop=%0d want 0 0", osop, oeop);
    end
    if (oerr) begin
      int unsigned ec;
      checks++;
      rx_errs++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_oerr at cyc %0d want none", cyc);
      end else begin
        ec = err_q.pop_front();
        if (cyc != ec) begin
          errors++;
          $display("FAIL oerr_timing got cyc %0d want cyc %0d", cyc, ec);
        end
      end
    end
  end

  task automatic drive(input bit v, input bit s, input bit d, input logic [7:0] eb);
    @(posedge iclk);
    #1;
    ival = v;
    isop = s;
    idat = d;
    if (v) begin
      if (s) begin
        if (in_pkt) begin
          err_q.push_back(cyc + 1);
          mod_errs++;
        end
        in_pkt = 1'b1;
        idx    = 0;
      end
      if (in_pkt) begin
        if (idx % 8 == 7) begin
          exp_q.push_back('{dat: eb, sop: (idx == 7), eop: (idx == LP - 1), cyc: cyc + 1});
          if (idx == LP - 1) mod_pkts++;
        end
        idx++;
        if (idx == LP) begin
          in_pkt = 1'b0;
          idx    = 0;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
    end
  endtask

  // Byte i of the stream carries (i + seed) mod 256; isop on every LP boundary.
  task automatic send_stream(input int unsigned nbits, input bit sop, input bit gap,
                             input int unsigned seed);
    logic [7:0] bv;
    for (int unsigned j = 0; j < nbits; j++) begin
      bv = 8'((j / 8 + seed) & 255);
      drive(1'b1, sop && (j % LP == 0), bv[3'(7 - j % 8)], bv);
      if (gap) idle(1);
    end
  endtask

  task automatic check_val(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge iclk);
    checks++;
    if (oval !== 1'b0 || osop !== 1'b0 || oeop !== 1'b0 || oerr !== 1'b0 || odat !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got val=%0d sop=%0d eop=%0d err=%0d dat=%h want all 0",
               oval, osop, oeop, oerr, odat);
    end
`ifdef DEPACK_STAT_EN
    check_val("reset_pkt_cnt", opkt_cnt, 0);
    check_val("reset_err_cnt", oerr_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge iclk);
    #1;
    ireset   = 1'b0;
    ival     = 1'b0;
    isop     = 1'b0;
    in_pkt   = 1'b0;
    idx      = 0;
    mod_pkts = 0;
    mod_errs = 0;
    repeat (3) check_reset_outputs();
    @(posedge iclk);
    #1;
    ireset = 1'b1;
  endtask

  task automatic check_stats();
`ifdef DEPACK_STAT_EN
    check_val("opkt_cnt", opkt_cnt, mod_pkts);
    check_val("oerr_cnt", oerr_cnt, mod_errs);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    int unsigned b0, e0;

    vecs[0] = '{nbits: LP,     sop: 1, gap: 0, seed: 0,  exp_bytes: 238, exp_errs: 0};
    vecs[1] = '{nbits: LP,     sop: 1, gap: 1, seed: 3,  exp_bytes: 238, exp_errs: 0};
    vecs[2] = '{nbits: 100,    sop: 1, gap: 0, seed: 5,  exp_bytes: 12,  exp_errs: 0};
    vecs[3] = '{nbits: LP,     sop: 1, gap: 0, seed: 9,  exp_bytes: 238, exp_errs: 1};
    vecs[4] = '{nbits: 500,    sop: 0, gap: 0, seed: 11, exp_bytes: 0,   exp_errs: 0};
    vecs[5] = '{nbits: 2 * LP, sop: 1, gap: 0, seed: 0,  exp_bytes: 476, exp_errs: 0};

    repeat (2) check_reset_outputs();
    @(posedge iclk);
    #1;
    ireset = 1'b1;
    idle(3);

    for (int unsigned r = 0; r < 6; r++) begin
      b0 = rx_bytes;
      e0 = rx_errs;
      send_stream(vecs[r].nbits, vecs[r].sop, vecs[r].gap, vecs[r].seed);
      idle(4);
      check_val($sformatf("row%0d_bytes", r), rx_bytes - b0, vecs[r].exp_bytes);
      check_val($sformatf("row%0d_errs", r), rx_errs - e0, vecs[r].exp_errs);
      check_stats();
    end

    // Abort one bit short of a full packet, then a clean packet.
    b0 = rx_bytes;
    e0 = rx_errs;
    send_stream(LP - 1, 1'b1, 1'b0, 20);
    send_stream(LP, 1'b1, 1'b0, 40);
    idle(4);
    check_val("short1_bytes", rx_bytes - b0, 237 + 238);
    check_val("short1_errs", rx_errs - e0, 1);
    check_stats();

    // Reset in the middle of a packet, then a fresh packet.
    send_stream(900, 1'b1, 1'b0, 60);
    do_reset();
    idle(2);
    b0 = rx_bytes;
    e0 = rx_errs;
    send_stream(LP, 1'b1, 1'b0, 70);
    idle(4);
    check_val("post_reset_bytes", rx_bytes - b0, 238);
    check_val("post_reset_errs", rx_errs - e0, 0);
    check_stats();

    check_val("exp_q_empty", exp_q.size(), 0);
    check_val("err_q_empty", err_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_to_byte_packer.md
Name: bit_to_byte_packer

Overview:
- Sits in the DeFEC chain directly downstream of the descrambler.
- Collects the serial descrambled bit stream (one bit per valid strobe) into bytes, MSB first.
- Frames each packet of LENGTH_PACK bits as a byte stream with start and end markers, for the byte-wide consumers that follow.
- Detects packets cut short by a premature start-of-packet, discards them and flags an error.

Parameters:
- LENGTH_PACK, 1904, packet length in bits. Must be a multiple of 8 and at least 16. Default gives 238 bytes per packet.
- CNT_W, 11, width of the bit counter. Must satisfy 2^CNT_W >= LENGTH_PACK.

Ports:
- iclk  input  1  system clock; all logic on rising edge.
- ireset  input  1  asynchronous active-low reset.
- isop  input  1  first bit of a packet; meaningful only when ival=1.
- ival  input  1  idat valid this cycle.
- idat  input  1  descrambled data bit.
- oval  output  1  odat holds a complete byte this cycle; single-cycle pulse per byte.
- osop  output  1  qualifies the first byte of a packet; high only with oval.
- oeop  output  1  qualifies the last byte (byte LENGTH_PACK/8) of a packet; high only with oval.
- odat  output  8  assembled byte; first received bit in odat[7].
- oerr  output  1  one-cycle pulse: current packet aborted short.
- opkt_cnt  output  16  completed-packet counter; present only with DEPACK_STAT_EN.
- oerr_cnt  output  16  aborted-packet counter; present only with DEPACK_STAT_EN.

Behaviour:
- Clock and reset: single clock iclk; asynchronous active-low reset ireset.
- Reset values: oval=0, osop=0, oeop=0, oerr=0, odat=8'h00. Internal state: IDLE, bit counter 0, shift register 0.
- Reset mid-packet: discards all partial data. No oerr is generated for the discarded packet.
- Accepted bit: any cycle with ival=1. Cycles with ival=0 change nothing, and isop with ival=0 is ignored.
- FSM IDLE:
  - Accepted bits without isop are dropped.
  - isop & ival: loads idat as bit 0 of a new packet, sets bit counter to 1, moves to RUN.
- FSM RUN:
  - Accepted bit without isop: shifts idat into the shift register (MSB first) and increments the bit counter.
  - When the accepted bit is bit index LENGTH_PACK-1, returns to IDLE and clears the counter.
- Byte output:
  - When an accepted bit completes a byte (counter mod 8 = 7 before the increment), the byte is registered.
  - oval=1 on the next clock edge, so latency is 1 cycle from the 8th bit's ival cycle to oval.
  - osop=1 with byte 0; oeop=1 with byte LENGTH_PACK/8-1.
  - odat holds its value between pulses and is valid only with oval.
- Abort (isop & ival while in RUN):
  - Partial packet discarded, including a partial byte. No further oval is emitted for the old packet.
  - oerr=1 on the next cycle.
  - The isop bit starts the new packet (counter=1, stays in RUN).
  - This applies even at counter=LENGTH_PACK-1, because the packet is one bit short.
- Same edge: a completing byte and an abort cannot coincide, because isop forces a new packet.
- Back-to-back packets: isop arriving in the cycle after the last bit is legal. It produces no error, and the next osop can follow the previous oeop after 8 accepted bits.
- Throughput: one bit per clock sustained. There is no backpressure.

Optional Feature:
- DEPACK_STAT_EN defined:
  - Adds outputs opkt_cnt and oerr_cnt, both reset to 0.
  - opkt_cnt increments on every oval&oeop; oerr_cnt increments on every oerr.
  - Both wrap modulo 2^16.
- DEPACK_STAT_EN undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then isop+ival on the first of 1904 contiguous bits forming bytes 0x00,0x01,...,0xED -> 238 oval pulses with odat=0x00..0xED. osop only on 0x00, oeop only on 0xED. Each oval lands 1 cycle after its 8th bit. oerr never asserts.
- Same packet with ival toggling 1/0 every cycle -> identical byte sequence with oval spaced 16 cycles apart. isop asserted while ival=0 mid-packet is ignored.
- 100 accepted bits (12 bytes out), then isop+ival -> oerr=1 one cycle later. The 4 leftover bits never appear, and the next 1904-bit packet is delivered correctly starting with osop.
- 500 accepted bits with no preceding isop -> no oval and no oerr. A following isop packet is delivered normally.
- Two packets back-to-back with no idle cycle -> 476 bytes and two osop/oeop pairs. With DEPACK_STAT_EN, opkt_cnt=2 and oerr_cnt=0; after the abort scenario, oerr_cnt=1.
- ireset driven low at bit 900 of a packet, released, then a fresh packet -> outputs 0 during reset, no oerr, and the fresh packet is delivered intact.
